// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enable SRAM: FSM state encoding and lane merge.
package sram_pkg;

    typedef enum logic {ST_INIT, ST_READY} sram_state_e;

    // Widest word/lane count lane_merge can handle; callers truncate the result to DW.
    localparam int LM_W  = 1024;
    localparam int LM_NB = 128;

    function automatic logic [LM_W-1:0] lane_merge(input logic [LM_W-1:0]  old_w,
                                                   input logic [LM_W-1:0]  new_w,
                                                   input logic [LM_NB-1:0] be,
                                                   input int               bw);
        logic [LM_W-1:0] r;
        r = old_w;
        for (int i = 0; i < LM_W; i++) begin
            if (be[i / bw]) r[i] = new_w[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_sram_be_if.sv
// Write/read request bus of the byte-enable SRAM; the requester is master, the memory is slave.
interface sync_sram_be_if #(
    parameter int DW = 256,
    parameter int AW = 8,
    parameter int BW = 8
);
    localparam int NB = DW / BW;

    logic          we;
    logic [AW-1:0] wa;
    logic [NB-1:0] wbe;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rvalid;
    logic          init_done;

    modport master (output we, wa, wbe, wd, re, ra,
                    input  rd, rvalid, init_done);

    modport slave  (input  we, wa, wbe, wd, re, ra,
                    output rd, rvalid, init_done);
endinterface

// File: rtl/sram_init_fsm.sv
// Post-reset clear sequencer: walks every address once, then holds READY until the next reset.
// Latency: init_done rises exactly DP cycles after reset release; no backpressure (free-running).
import sram_pkg::*;

module sram_init_fsm #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic          init_done
);
    localparam int DP = 1 << AW;

    sram_state_e   state;
    logic [AW-1:0] init_cnt;

    // Explicit terminal compare keeps init_cnt from wrapping into a second pass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == AW'(DP - 1)) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt  <= init_cnt + AW'(1);
                    end
                end
                default: begin
                    state     <= ST_READY;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    assign init_we   = (state == ST_INIT);
    assign init_addr = init_cnt;

endmodule

// File: rtl/sync_sram_be.sv
// Simple-dual-port SRAM with byte-lane writes, write-first collision forwarding and post-reset clear.
// Latency: 1 cycle read-to-rvalid, 2 with SRAM_OUT_REG_EN; no backpressure, requests gated by init_done.
import sram_pkg::*;

module sync_sram_be #(
    parameter int                     DW       = 256,
    parameter int                     AW       = 8,
    parameter int                     BW       = 8,
    parameter logic [DW-1:0]          INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    sync_sram_be_if.slave bus
);
    localparam int NB = DW / BW;
    localparam int DP = 1 << AW;

    if ((DW % BW) != 0) begin : g_bad_bw
        $error("sync_sram_be: DW (%0d) must be a multiple of BW (%0d)", DW, BW);
    end
    if (DW > LM_W || NB > LM_NB) begin : g_too_wide
        $error("sync_sram_be: DW/NB exceed lane_merge limits");
    end

    logic          init_we;
    logic [AW-1:0] init_addr;
    logic          init_done;

    sram_init_fsm #(.AW(AW)) u_init (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_done (init_done)
    );

    logic [DW-1:0] mem [DP];

    logic          mem_init_we;
    logic          usr_we;
    logic          usr_re;
    logic [DW-1:0] rd_old;
    logic [DW-1:0] rd_fwd;

    // Reset outranks everything, including an in-progress clear or a user write.
    assign mem_init_we = rst_n & init_we;
    assign usr_we      = rst_n & init_done & bus.we;
    assign usr_re      = init_done & bus.re;

    always_ff @(posedge clk) begin
        if (mem_init_we) begin
            mem[init_addr] <= INIT_VAL;
        end else if (usr_we) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i]) mem[bus.wa][i*BW +: BW] <= bus.wd[i*BW +: BW];
            end
        end
    end

    // Write-first: a same-address write shows its enabled lanes in this read.
    assign rd_old = mem[bus.ra];
    assign rd_fwd = (usr_we && (bus.wa == bus.ra))
                  ? DW'(lane_merge(LM_W'(rd_old), LM_W'(bus.wd), LM_NB'(bus.wbe), BW))
                  : rd_old;

    logic [DW-1:0] rd_s1;
    logic          vld_s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_s1  <= '0;
            vld_s1 <= 1'b0;
        end else begin
            vld_s1 <= usr_re;
            if (usr_re) rd_s1 <= rd_fwd;
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [DW-1:0] rd_s2;
    logic          vld_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_s2  <= '0;
            vld_s2 <= 1'b0;
        end else begin
            vld_s2 <= vld_s1;
            if (vld_s1) rd_s2 <= rd_s1;
        end
    end

    assign bus.rd     = rd_s2;
    assign bus.rvalid = vld_s2;
`else
    assign bus.rd     = rd_s1;
    assign bus.rvalid = vld_s1;
`endif

    assign bus.init_done = init_done;

endmodule
